// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcode table, flag bit positions
// and the response-register state encoding.
package alu_pkg;

    // Team ALU opcode table
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_RSV = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_LT  = 4'hC;
    localparam logic [3:0] OP_GT  = 4'hD;
    localparam logic [3:0] OP_NE  = 4'hE;
    localparam logic [3:0] OP_EQ  = 4'hF;

    // Bit positions inside the 4-bit flags word {Zero, Carry, Sign, Error}
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_E = 0;

    // Output register occupancy
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU shared by all requesters of alu_sched.
// Carry is only meaningful for ADD/SUB (bit 4 of the 5-bit result); Error is
// raised for DIV/MOD by zero, which also force the result to 0.
module alu4_core
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] result_o,
    output logic [3:0] flags_o
);

    logic [4:0] wideSum;
    logic       carry;
    logic       err;

    // Decode the opcode and form result plus Zero/Carry/Sign/Error flags
    always_comb begin
        wideSum  = '0;
        carry    = 1'b0;
        err      = 1'b0;
        result_o = '0;
        case (op_i)
            OP_ADD: begin
                wideSum  = {1'b0, a_i} + {1'b0, b_i};
                result_o = wideSum[3:0];
                carry    = wideSum[4];
            end
            OP_SUB: begin
                wideSum  = {1'b0, a_i} - {1'b0, b_i};
                result_o = wideSum[3:0];
                carry    = wideSum[4];
            end
            OP_MUL: result_o = a_i * b_i;
            OP_DIV: begin
                if (b_i == 4'd0) err = 1'b1;
                else             result_o = a_i / b_i;
            end
            OP_MOD: begin
                if (b_i == 4'd0) err = 1'b1;
                else             result_o = a_i % b_i;
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_RSV: result_o = '0;
            OP_SHL: result_o = a_i << b_i;
            OP_SHR: result_o = a_i >> b_i;
            OP_LT:  result_o = {3'b000, (a_i < b_i)};
            OP_GT:  result_o = {3'b000, (a_i > b_i)};
            OP_NE:  result_o = {3'b000, (a_i != b_i)};
            OP_EQ:  result_o = {3'b000, (a_i == b_i)};
            default: result_o = '0;
        endcase
        flags_o         = '0;
        flags_o[FLAG_Z] = (result_o == 4'd0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_S] = result_o[3];
        flags_o[FLAG_E] = err;
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu4_core among NREQ requesters, with a
// single registered response port under backpressure.
// Optional build macro ALU_SCHED_STATS_EN adds saturating completion/error
// counters; without it stat_ops_o/stat_err_o are tied to zero.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TAGW = $clog2(NREQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [4*NREQ-1:0] req_op_i,
    input  logic [4*NREQ-1:0] req_a_i,
    input  logic [4*NREQ-1:0] req_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [3:0]        rsp_result_o,
    output logic [3:0]        rsp_flags_o,
    output logic [TAGW-1:0]   rsp_tag_o,
    output logic [15:0]       stat_ops_o,
    output logic [7:0]        stat_err_o
);

    rsp_state_e      state_q;
    logic [TAGW-1:0] ptr_q;
    logic [3:0]      rspResult_q;
    logic [3:0]      rspFlags_q;
    logic [TAGW-1:0] rspTag_q;

    logic [TAGW-1:0] candIdx;
    logic [TAGW-1:0] grantIdx;
    logic            grantValid;
    logic            slotFree;
    logic            grantFire;
    logic [3:0]      grantOp;
    logic [3:0]      grantA;
    logic [3:0]      grantB;
    logic [3:0]      aluResult;
    logic [3:0]      aluFlags;

    // Find the first valid requester after ptr; scanning from the far end
    // lets the nearest candidate overwrite the others
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            candIdx = TAGW'((int'(ptr_q) + k) % NREQ);
            if (req_valid_i[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    assign slotFree  = (state_q == RSP_EMPTY) || rsp_ready_i;
    assign grantFire = slotFree && grantValid && !rst_i;

    // One-hot accept for the granted requester, silenced during reset
    always_comb begin
        req_ready_o = '0;
        if (grantFire) req_ready_o[grantIdx] = 1'b1;
    end

    assign grantOp = req_op_i[4*grantIdx +: 4];
    assign grantA  = req_a_i[4*grantIdx +: 4];
    assign grantB  = req_b_i[4*grantIdx +: 4];

    alu4_core u_core (
        .op_i     (grantOp),
        .a_i      (grantA),
        .b_i      (grantB),
        .result_o (aluResult),
        .flags_o  (aluFlags)
    );

    // Response register FSM: load on grant, empty on drain without refill
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RSP_EMPTY;
            rspResult_q <= '0;
            rspFlags_q  <= '0;
            rspTag_q    <= '0;
            ptr_q       <= TAGW'(NREQ - 1);
        end else if (grantFire) begin
            state_q     <= RSP_FULL;
            rspResult_q <= aluResult;
            rspFlags_q  <= aluFlags;
            rspTag_q    <= grantIdx;
            ptr_q       <= grantIdx;
        end else if ((state_q == RSP_FULL) && rsp_ready_i) begin
            state_q     <= RSP_EMPTY;
        end
    end

    assign rsp_valid_o  = (state_q == RSP_FULL);
    assign rsp_result_o = rspResult_q;
    assign rsp_flags_o  = rspFlags_q;
    assign rsp_tag_o    = rspTag_q;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] statOps_q;
    logic [7:0]  statErr_q;
    logic        rspFire;

    assign rspFire = rsp_valid_o && rsp_ready_i;

    // Saturating counts of completed responses and of those flagged Error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            statOps_q <= '0;
            statErr_q <= '0;
        end else if (rspFire) begin
            if (statOps_q != 16'hFFFF) statOps_q <= statOps_q + 16'd1;
            if (rspFlags_q[FLAG_E] && (statErr_q != 8'hFF)) statErr_q <= statErr_q + 8'd1;
        end
    end

    assign stat_ops_o = statOps_q;
    assign stat_err_o = statErr_q;
`else
    assign stat_ops_o = '0;
    assign stat_err_o = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Honours ALU_SCHED_STATS_EN to select the expected counter behaviour.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int TAGW = 2;

`ifdef ALU_SCHED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ-1:0]   reqReady;
    logic [4*NREQ-1:0] reqOp;
    logic [4*NREQ-1:0] reqA;
    logic [4*NREQ-1:0] reqB;
    logic              rspValid;
    logic              rspReady;
    logic [3:0]        rspResult;
    logic [3:0]        rspFlags;
    logic [TAGW-1:0]   rspTag;
    logic [15:0]       statOps;
    logic [7:0]        statErr;

    int nVectors     = 0;
    int nMiscompares = 0;

    // Behavioural model state
    bit mValid  = 1'b0;
    int mResult = 0;
    int mFlags  = 0;
    int mTag    = 0;
    int mPtr    = NREQ - 1;
    int mOps    = 0;
    int mErr    = 0;

    // Free-running clock
    always #5 clk = ~clk;

    alu_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_op_i     (reqOp),
        .req_a_i      (reqA),
        .req_b_i      (reqB),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_result_o (rspResult),
        .rsp_flags_o  (rspFlags),
        .rsp_tag_o    (rspTag),
        .stat_ops_o   (statOps),
        .stat_err_o   (statErr)
    );

    // Reference ALU from plain integer arithmetic; returns {result, flags}
    function automatic logic [7:0] aluModel(input int op, input int a, input int b);
        int r;
        bit c;
        bit e;
        logic [7:0] v;
        r = 0; c = 1'b0; e = 1'b0;
        case (op)
            0:  begin r = a + b; c = (r > 15); end
            1:  begin r = a - b; c = (a < b); end
            2:  r = a * b;
            3:  if (b == 0) e = 1'b1; else r = a / b;
            4:  if (b == 0) e = 1'b1; else r = a % b;
            5:  r = a & b;
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = ~a;
            9:  r = 0;
            10: r = (b > 3) ? 0 : (a << b);
            11: r = a >> b;
            12: r = (a < b)  ? 1 : 0;
            13: r = (a > b)  ? 1 : 0;
            14: r = (a != b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        r = r & 15;
        v[7:4] = r[3:0];
        v[3]   = (r == 0);
        v[2]   = c;
        v[1]   = (r >= 8);
        v[0]   = e;
        return v;
    endfunction

    // Round-robin choice: first valid requester after ptr, or -1
    function automatic int expGrant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setReq(input int i, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        reqOp[4*i +: 4] = op;
        reqA[4*i +: 4]  = a;
        reqB[4*i +: 4]  = b;
    endtask

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic rr);
        rst      = r;
        reqValid = v;
        rspReady = rr;
    endtask

    task automatic randomizeOperands();
        for (int i = 0; i < NREQ; i++) begin
            setReq(i, 4'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic checkOutput();
        int g;
        logic [NREQ-1:0] er;
        g  = expGrant(reqValid, mPtr);
        er = '0;
        if (!rst && (!mValid || rspReady) && g >= 0) er[g] = 1'b1;
        cmp("req_ready", 32'(reqReady), 32'(er));
        cmp("rsp_valid", 32'(rspValid), 32'(mValid));
        if (mValid) begin
            cmp("rsp_result", 32'(rspResult), mResult);
            cmp("rsp_flags",  32'(rspFlags),  mFlags);
            cmp("rsp_tag",    32'(rspTag),    mTag);
        end
        cmp("stat_ops", 32'(statOps), STATS_ON ? mOps : 0);
        cmp("stat_err", 32'(statErr), STATS_ON ? mErr : 0);
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelUpdate();
        int g;
        logic [7:0] v;
        bit free;
        if (rst) begin
            mValid = 1'b0; mResult = 0; mFlags = 0; mTag = 0;
            mPtr = NREQ - 1; mOps = 0; mErr = 0;
        end else begin
            g    = expGrant(reqValid, mPtr);
            free = !mValid || rspReady;
            if (mValid && rspReady) begin
                if (mOps < 65535) mOps++;
                if ((mFlags & 1) != 0 && mErr < 255) mErr++;
            end
            if (free && g >= 0) begin
                v = aluModel(int'(reqOp[4*g +: 4]), int'(reqA[4*g +: 4]), int'(reqB[4*g +: 4]));
                mValid  = 1'b1;
                mResult = int'(v[7:4]);
                mFlags  = int'(v[3:0]);
                mTag    = g;
                mPtr    = g;
            end else if (mValid && rspReady) begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    // Main sequence: directed scenarios, random traffic, counter saturation
    initial begin
        logic [3:0]      heldResult;
        logic [3:0]      heldFlags;
        logic [TAGW-1:0] heldTag;

        reqOp = '0; reqA = '0; reqB = '0;
        applyStimulus(1'b1, '1, 1'b1);
        randomizeOperands();
        @(posedge clk);
        modelUpdate();
        #1;
        step();
        cmp("reset_rsp_valid", 32'(rspValid), 0);
        cmp("reset_rsp_result", 32'(rspResult), 0);
        cmp("reset_rsp_flags", 32'(rspFlags), 0);
        cmp("reset_rsp_tag", 32'(rspTag), 0);
        cmp("reset_stat_ops", 32'(statOps), 0);
        cmp("reset_stat_err", 32'(statErr), 0);
        cmp("reset_req_ready", 32'(reqReady), 0);

        // Single ADD 9+8 from requester 0
        applyStimulus(1'b0, 4'b0001, 1'b1);
        setReq(0, OP_ADD, 4'd9, 4'd8);
        step();
        cmp("add_valid", 32'(rspValid), 1);
        cmp("add_result", 32'(rspResult), 1);
        cmp("add_flags", 32'(rspFlags), 32'b0100);
        cmp("add_tag", 32'(rspTag), 0);

        // Divide by zero from requester 2
        applyStimulus(1'b0, 4'b0100, 1'b1);
        setReq(2, OP_DIV, 4'd7, 4'd0);
        step();
        cmp("div0_result", 32'(rspResult), 0);
        cmp("div0_flags", 32'(rspFlags), 32'b1001);
        cmp("div0_tag", 32'(rspTag), 2);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        step();
        cmp("div0_drained", 32'(rspValid), 0);
        cmp("div0_stat_err", 32'(statErr), STATS_ON ? 1 : 0);

        // Round robin with every requester valid
        applyStimulus(1'b1, 4'b0000, 1'b1);
        step();
        applyStimulus(1'b0, 4'b1111, 1'b1);
        randomizeOperands();
        for (int i = 0; i < 6; i++) begin
            step();
            cmp("rr_valid", 32'(rspValid), 1);
            cmp("rr_tag", 32'(rspTag), i % NREQ);
        end

        // Backpressure: hold the response while requester 1 waits
        heldResult = rspResult;
        heldFlags  = rspFlags;
        heldTag    = rspTag;
        applyStimulus(1'b0, 4'b0010, 1'b0);
        setReq(1, OP_SUB, 4'd3, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp("bp_req_ready", 32'(reqReady), 0);
            step();
            cmp("bp_valid", 32'(rspValid), 1);
            cmp("bp_result", 32'(rspResult), 32'(heldResult));
            cmp("bp_flags", 32'(rspFlags), 32'(heldFlags));
            cmp("bp_tag", 32'(rspTag), 32'(heldTag));
        end
        rspReady = 1'b1;
        #1;
        cmp("bp_release_ready", 32'(reqReady), 32'b0010);
        step();
        cmp("bp_new_tag", 32'(rspTag), 1);
        cmp("bp_new_result", 32'(rspResult), 14);
        cmp("bp_new_flags", 32'(rspFlags), 32'b0110);

        // Reset while a response is held, then priority restarts at 0
        applyStimulus(1'b1, 4'b0010, 1'b0);
        step();
        cmp("rstmid_valid", 32'(rspValid), 0);
        cmp("rstmid_stat_ops", 32'(statOps), 0);
        cmp("rstmid_stat_err", 32'(statErr), 0);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        setReq(0, OP_AND, 4'd12, 4'd10);
        setReq(3, OP_OR, 4'd1, 4'd2);
        step();
        cmp("rstmid_tag", 32'(rspTag), 0);
        cmp("rstmid_result", 32'(rspResult), 8);
        cmp("rstmid_flags", 32'(rspFlags), 32'b0010);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 199) == 0), NREQ'($urandom), ($urandom_range(0, 3) != 0));
            randomizeOperands();
            step();
        end

        // Counter saturation: a stream of erroring completions
        applyStimulus(1'b1, 4'b0000, 1'b1);
        step();
        applyStimulus(1'b0, 4'b0001, 1'b1);
        setReq(0, OP_DIV, 4'd5, 4'd0);
        for (int n = 0; n < 65545; n++) begin
            step();
        end
        cmp("sat_stat_ops", 32'(statOps), STATS_ON ? 32'hFFFF : 0);
        cmp("sat_stat_err", 32'(statErr), STATS_ON ? 32'hFF : 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
